// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the multi-channel clock frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    REPORT = 2'd2
  } state_e;

  // 1 ms gate window at a 50 MHz system clock.
  localparam int DEFAULT_GATE_CYCLES = 50000;

  function automatic int chWidth(input int numCh);
    return (numCh > 1) ? $clog2(numCh) : 1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Brings one asynchronous clock into the clk domain and emits a one-cycle
// pulse for every rising edge seen at the synchronizer output.
module sync_edge_det
  import freq_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] syncChain_q;
  logic                   delayed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      syncChain_q <= '0;
      delayed_q   <= 1'b0;
    end else begin
      syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], d};
      delayed_q   <= syncChain_q[SYNC_STAGES-1];
    end
  end

  assign rise = syncChain_q[SYNC_STAGES-1] & ~delayed_q;

endmodule

// File: rtl/freq_meter.sv
// Round-robin edge counter: counts rising edges of each sig_in channel over a
// fixed gate window of clk and publishes the result with overflow/dead flags.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  GATE_CYCLES = DEFAULT_GATE_CYCLES,
  parameter int  CNT_W       = 16,
  parameter int  SYNC_STAGES = 2,
  localparam int CH_W        = chWidth(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] sig_in,
  output logic              meas_valid,
  output logic [CH_W-1:0]   meas_ch,
  output logic [CNT_W-1:0]  meas_count,
  output logic              meas_ovf,
  output logic [NUM_CH-1:0] sig_dead
);

  localparam int               GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) + 1 : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [NUM_CH-1:0] rise;

  for (genvar i = 0; i < NUM_CH; i++) begin : gSync
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) uSync (
      .clk  (clk),
      .rst  (rst),
      .d    (sig_in[i]),
      .rise (rise[i])
    );
  end

  state_e            state_q, state_d;
  logic [GW-1:0]     gateCnt_q, gateCnt_d;
  logic [CNT_W-1:0]  edgeCnt_q, edgeCnt_d;
  logic              ovf_q, ovf_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              measValid_q, measValid_d;
  logic [CH_W-1:0]   measCh_q, measCh_d;
  logic [CNT_W-1:0]  measCount_q, measCount_d;
  logic              measOvf_q, measOvf_d;
  logic [NUM_CH-1:0] sigDead_q, sigDead_d;
  logic              counting, reportNow;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = GATE;
      GATE:    if (!en) state_d = IDLE;
               else if (gateCnt_q == GATE_LAST) state_d = REPORT;
      REPORT:  state_d = en ? GATE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    counting  = (state_q == GATE) && en;
    reportNow = (state_q == REPORT);
  end

  // Anything other than an active GATE cycle clears the window, which also
  // discards partial counts on abort and edges arriving in REPORT/IDLE.
  always_comb begin
    gateCnt_d   = '0;
    edgeCnt_d   = '0;
    ovf_d       = 1'b0;
    ch_d        = ch_q;
    measValid_d = reportNow;
    measCh_d    = measCh_q;
    measCount_d = measCount_q;
    measOvf_d   = measOvf_q;
    sigDead_d   = sigDead_q;
    if (counting) begin
      gateCnt_d = gateCnt_q + 1'b1;
      edgeCnt_d = edgeCnt_q;
      ovf_d     = ovf_q;
      if (rise[ch_q]) begin
        if (edgeCnt_q == CNT_MAX) ovf_d = 1'b1;
        else                      edgeCnt_d = edgeCnt_q + 1'b1;
      end
    end
    if (reportNow) begin
      measCh_d        = ch_q;
      measCount_d     = edgeCnt_q;
      measOvf_d       = ovf_q;
      sigDead_d[ch_q] = (edgeCnt_q == '0);
      ch_d            = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gateCnt_q   <= '0;
      edgeCnt_q   <= '0;
      ovf_q       <= 1'b0;
      ch_q        <= '0;
      measValid_q <= 1'b0;
      measCh_q    <= '0;
      measCount_q <= '0;
      measOvf_q   <= 1'b0;
      sigDead_q   <= '0;
    end else begin
      gateCnt_q   <= gateCnt_d;
      edgeCnt_q   <= edgeCnt_d;
      ovf_q       <= ovf_d;
      ch_q        <= ch_d;
      measValid_q <= measValid_d;
      measCh_q    <= measCh_d;
      measCount_q <= measCount_d;
      measOvf_q   <= measOvf_d;
      sigDead_q   <= sigDead_d;
    end
  end

  assign meas_valid = measValid_q;
  assign meas_ch    = measCh_q;
  assign meas_count = measCount_q;
  assign meas_ovf   = measOvf_q;
  assign sig_dead   = sigDead_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 16-bit instance for the main scenarios and a
// 4-bit counter instance for saturation, both on a 100-cycle gate window.
module tb_freq_meter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] sigIn;

  logic       c0 = 1'b0, c1 = 1'b0, c2 = 1'b0, c3 = 1'b0;
  logic       ch2Run = 1'b1;
  logic [1:0] ch1Mode = 2'd0;
  logic       ch1Manual = 1'b0;

  logic        measValidA, measOvfA;
  logic [1:0]  measChA;
  logic [15:0] measCountA;
  logic [3:0]  sigDeadA;

  logic        measValidB, measOvfB;
  logic [1:0]  measChB;
  logic [3:0]  measCountB;
  logic [3:0]  sigDeadB;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  freq_meter #(.NUM_CH(4), .GATE_CYCLES(100), .CNT_W(16), .SYNC_STAGES(2)) dutA (
    .clk(clk), .rst(rst), .en(en), .sig_in(sigIn),
    .meas_valid(measValidA), .meas_ch(measChA), .meas_count(measCountA),
    .meas_ovf(measOvfA), .sig_dead(sigDeadA)
  );

  freq_meter #(.NUM_CH(4), .GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)) dutB (
    .clk(clk), .rst(rst), .en(en), .sig_in(sigIn),
    .meas_valid(measValidB), .meas_ch(measChB), .meas_count(measCountB),
    .meas_ovf(measOvfB), .sig_dead(sigDeadB)
  );

  // 50 MHz system clock; measured clocks are offset so no edge meets a clk edge.
  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin #3;  forever #100 c0 = ~c0; end
  initial begin #13; forever #100 c1 = ~c1; end
  initial begin #7;  forever #40  c2 = ~c2; end
  initial begin #5;  forever #200 c3 = ~c3; end

  always_comb sigIn = {c3, c2 & ch2Run,
                       (ch1Mode == 2'd1) ? c1 : ((ch1Mode == 2'd2) ? ch1Manual : 1'b0),
                       c0};

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_valid_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (measValidA === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_valid_b(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (measValidB === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit saw;
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (measValidA !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", measValidA); end
    checks++; if (measChA !== 2'd0) begin failures++; $display("[TB] FAIL reset_ch: got %0d expected 0", measChA); end
    checks++; if (measCountA !== 16'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", measCountA); end
    checks++; if (measOvfA !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf: got %b expected 0", measOvfA); end
    checks++; if (sigDeadA !== 4'b0000) begin failures++; $display("[TB] FAIL reset_dead: got %b expected 0000", sigDeadA); end
    checks++; if (measCountB !== 4'd0) begin failures++; $display("[TB] FAIL reset_count_b: got %0d expected 0", measCountB); end
    rst = 1'b0;
    saw = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (measValidA !== 1'b0) saw = 1'b1;
    end
    checks++; if (saw) begin failures++; $display("[TB] FAIL idle_no_valid: got valid expected none"); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int lastCyc;
    int expCh[5] = '{0, 1, 2, 3, 0};
    int lo[5]    = '{9, 0, 24, 4, 9};
    int hi[5]    = '{11, 0, 26, 6, 11};
    en = 1'b1;
    lastCyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_valid_a(150, ok);
      checks++;
      if (!ok) begin failures++; $display("[TB] FAIL rr_timeout%0d: got none expected valid", k); end
      checks++;
      if (measChA !== 2'(expCh[k])) begin failures++; $display("[TB] FAIL rr_ch%0d: got %0d expected %0d", k, measChA, expCh[k]); end
      checks++;
      if ($isunknown(measCountA) || int'(measCountA) < lo[k] || int'(measCountA) > hi[k]) begin
        failures++; $display("[TB] FAIL rr_count%0d: got %0d expected %0d..%0d", k, measCountA, lo[k], hi[k]);
      end
      if (k > 0) begin
        checks++;
        if (cyc - lastCyc != 101) begin failures++; $display("[TB] FAIL rr_period%0d: got %0d expected 101", k, cyc - lastCyc); end
      end
      if (k == 3) begin
        checks++;
        if (sigDeadA !== 4'b0010) begin failures++; $display("[TB] FAIL rr_dead: got %b expected 0010", sigDeadA); end
      end
      lastCyc = cyc;
      if (k == 0) begin
        @(negedge clk);
        checks++;
        if (measValidA !== 1'b0) begin failures++; $display("[TB] FAIL rr_pulse: got %b expected 0", measValidA); end
        checks++;
        if (measChA !== 2'd0 || measOvfA !== 1'b0) begin failures++; $display("[TB] FAIL rr_hold: got ch %0d ovf %b expected ch 0 ovf 0", measChA, measOvfA); end
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    bit found;
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      wait_valid_b(150, ok);
      if (ok && measChB === 2'd2) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("[TB] FAIL ovf_find: got none expected ch2 result"); end
    checks++;
    if (measCountB !== 4'd15) begin failures++; $display("[TB] FAIL ovf_count: got %0d expected 15", measCountB); end
    checks++;
    if (measOvfB !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag: got %b expected 1", measOvfB); end
    wait_valid_b(150, ok);
    checks++;
    if (!ok || measChB !== 2'd3) begin failures++; $display("[TB] FAIL ovf_next_ch: got %0d expected 3", measChB); end
    checks++;
    if (measOvfB !== 1'b0) begin failures++; $display("[TB] FAIL ovf_next_flag: got %b expected 0", measOvfB); end
    checks++;
    if (measCountB < 4'd4 || measCountB > 4'd6) begin failures++; $display("[TB] FAIL ovf_next_count: got %0d expected 4..6", measCountB); end
  endtask

  task automatic test_en_abort();
    bit ok;
    bit saw;
    int startCyc;
    repeat (50) @(negedge clk);
    en = 1'b0;
    saw = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (measValidA !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw) begin failures++; $display("[TB] FAIL abort_valid: got valid expected none"); end
    checks++;
    if (measChA !== 2'd3) begin failures++; $display("[TB] FAIL abort_hold_ch: got %0d expected 3", measChA); end
    en = 1'b1;
    startCyc = cyc;
    wait_valid_a(150, ok);
    checks++;
    if (!ok || measChA !== 2'd0) begin failures++; $display("[TB] FAIL abort_resume_ch: got %0d expected 0", measChA); end
    checks++;
    if (measCountA < 16'd9 || measCountA > 16'd11) begin failures++; $display("[TB] FAIL abort_resume_count: got %0d expected 9..11", measCountA); end
    checks++;
    if (cyc - startCyc < 101) begin failures++; $display("[TB] FAIL abort_window: got %0d cycles expected >=101", cyc - startCyc); end
  endtask

  task automatic test_reset_midgate();
    bit ok;
    wait_valid_a(150, ok);
    checks++;
    if (!ok || measChA !== 2'd1) begin failures++; $display("[TB] FAIL rstmid_pre_ch: got %0d expected 1", measChA); end
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (measValidA !== 1'b0 || measChA !== 2'd0 || measCountA !== 16'd0 || measOvfA !== 1'b0 || sigDeadA !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL rstmid_outputs: got v%b ch%0d cnt%0d ovf%b dead%b expected all 0",
               measValidA, measChA, measCountA, measOvfA, sigDeadA);
    end
    rst = 1'b0;
    wait_valid_a(150, ok);
    checks++;
    if (!ok || measChA !== 2'd0) begin failures++; $display("[TB] FAIL rstmid_first_ch: got %0d expected 0", measChA); end
  endtask

  task automatic test_dead_recovery();
    bit ok;
    logic [1:0] expCh[3] = '{2'd2, 2'd3, 2'd0};
    wait_valid_a(150, ok);
    checks++;
    if (!ok || measChA !== 2'd1 || measCountA !== 16'd0) begin failures++; $display("[TB] FAIL dead_ch1: got ch%0d cnt%0d expected ch1 cnt0", measChA, measCountA); end
    checks++;
    if (sigDeadA !== 4'b0010) begin failures++; $display("[TB] FAIL dead_set: got %b expected 0010", sigDeadA); end
    ch1Mode = 2'd1;
    for (int k = 0; k < 3; k++) begin
      wait_valid_a(150, ok);
      checks++;
      if (!ok || measChA !== expCh[k] || sigDeadA !== 4'b0010) begin
        failures++; $display("[TB] FAIL dead_hold%0d: got ch%0d dead%b expected ch%0d dead0010", k, measChA, sigDeadA, expCh[k]);
      end
    end
    wait_valid_a(150, ok);
    checks++;
    if (!ok || measChA !== 2'd1 || measCountA < 16'd9 || measCountA > 16'd11) begin
      failures++; $display("[TB] FAIL dead_revive_count: got ch%0d cnt%0d expected ch1 cnt 9..11", measChA, measCountA);
    end
    checks++;
    if (sigDeadA !== 4'b0000) begin failures++; $display("[TB] FAIL dead_clear: got %b expected 0000", sigDeadA); end
  endtask

  task automatic test_edge_before_report();
    bit ok;
    ch1Mode   = 2'd2;
    ch1Manual = 1'b0;
    ch2Run    = 1'b0;
    for (int k = 0; k < 3; k++) wait_valid_a(150, ok);
    checks++;
    if (!ok || measChA !== 2'd0) begin failures++; $display("[TB] FAIL edge_sync_ch: got %0d expected 0", measChA); end
    // The valid cycle is gate count 0 of ch1, so 99 more cycles is its last GATE cycle.
    repeat (99) @(negedge clk);
    ch1Manual = 1'b1;
    wait_valid_a(150, ok);
    checks++;
    if (!ok || measChA !== 2'd1 || measCountA > 16'd1) begin failures++; $display("[TB] FAIL edge_ch1_count: got ch%0d cnt%0d expected ch1 cnt 0..1", measChA, measCountA); end
    wait_valid_a(150, ok);
    checks++;
    if (!ok || measChA !== 2'd2 || measCountA !== 16'd0) begin failures++; $display("[TB] FAIL edge_ch2_count: got ch%0d cnt%0d expected ch2 cnt0", measChA, measCountA); end
    checks++;
    if (sigDeadA[2] !== 1'b1) begin failures++; $display("[TB] FAIL edge_ch2_dead: got %b expected 1", sigDeadA[2]); end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_round_robin();
    test_overflow();
    test_en_abort();
    test_reset_midgate();
    test_dead_recovery();
    test_edge_before_report();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
